descrambler_sync: RTL

Receive-side counterpart of the 802.11-style additive scrambler, using polynomial x^7 + x^4 + 1.
- Serial bitstream in, serial bitstream out, with valid qualifiers.
- Seed source, per frame, is one of:
  - loaded explicitly, matching the transmitter's seed/load interface;
  - auto-recovered from the first 7 bits of the SERVICE field, whose plaintext is all zeros.
- Checks the remaining SERVICE bits, reports lock/error, and optionally strips SERVICE bits before passing payload downstream.

---
 rtl/descrambler_sync_if.sv | 24 ++
 rtl/descrambler_sync.sv | 136 +++++++++++++
 2 files changed

// File: rtl/descrambler_sync_if.sv
// Bit-serial bus between a receive front end and the descrambler:
// seed/load control, frame delimiting, data in/out and status.
interface descrambler_sync_if;
  logic [6:0] seed;
  logic       load;
  logic       auto_sync;
  logic       frame_start;
  logic       din;
  logic       din_valid;
  logic       dout;
  logic       dout_valid;
  logic       locked;
  logic       service_err;

  modport master (
    output seed, load, auto_sync, frame_start, din, din_valid,
    input  dout, dout_valid, locked, service_err
  );

  modport slave (
    input  seed, load, auto_sync, frame_start, din, din_valid,
    output dout, dout_valid, locked, service_err
  );
endinterface

// File: rtl/descrambler_sync.sv
// Additive descrambler for x^7 + x^4 + 1 with seed recovery from the
// all-zero SERVICE field, SERVICE checking and optional SERVICE stripping.
module descrambler_sync #(
  parameter int SERVICE_BITS  = 16,
  parameter bit STRIP_SERVICE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  descrambler_sync_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [6:0] SYNC_LAST    = 7'd7;
  localparam logic [6:0] SERVICE_LAST = 7'(SERVICE_BITS);

  state_e     state_q, state_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] cnt_q, cnt_d;
  logic       dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       fb;
  logic       plain;

  // Next-state: control events first select the frame context, then the
  // accepted bit is processed in that context.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    locked_d     = locked_q;
    err_d        = err_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;

    if (bus.load) begin
      lfsr_d   = bus.seed;
      state_d  = RUN;
      locked_d = 1'b1;
      err_d    = 1'b0;
    end else if (bus.frame_start) begin
      err_d = 1'b0;
      if (bus.auto_sync) begin
        state_d  = SYNC;
        cnt_d    = 7'd0;
        locked_d = 1'b0;
      end else begin
        state_d  = RUN;
        locked_d = 1'b1;
      end
    end else begin
      state_d = state_q;
    end

    // A same-cycle load or frame_start bit uses the freshly selected LFSR.
    fb    = lfsr_d[6] ^ lfsr_d[3];
    plain = bus.din ^ fb;

    if (bus.din_valid) begin
      case (state_d)
        SYNC: begin
          lfsr_d       = {lfsr_d[5:0], bus.din};
          dout_valid_d = ~STRIP_SERVICE;
          cnt_d        = cnt_d + 7'd1;
          if (cnt_d == SYNC_LAST) begin
            if (SERVICE_BITS == 7) begin
              state_d  = RUN;
              locked_d = 1'b1;
            end else begin
              state_d = CHECK;
            end
          end else begin
            state_d = SYNC;
          end
        end
        CHECK: begin
          lfsr_d       = {lfsr_d[5:0], fb};
          dout_d       = plain & ~STRIP_SERVICE;
          dout_valid_d = ~STRIP_SERVICE;
          err_d        = err_d | plain;
          cnt_d        = cnt_d + 7'd1;
          if (cnt_d == SERVICE_LAST) begin
            state_d  = RUN;
            locked_d = ~err_d;
          end else begin
            state_d = CHECK;
          end
        end
        RUN: begin
          lfsr_d       = {lfsr_d[5:0], fb};
          dout_d       = plain;
          dout_valid_d = 1'b1;
        end
        default: begin
          dout_valid_d = 1'b0;
        end
      endcase
    end else begin
      dout_valid_d = 1'b0;
    end
  end

  // State and registered outputs; reset drops any in-flight output bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= 7'h7F;
      cnt_q        <= 7'd0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.locked      = locked_q;
  assign bus.service_err = err_q;

endmodule
